// File: rtl/eeprom_pkg.sv
// Shared definitions for the serial-EEPROM command sequencer, controller and bench model.
// Holds the sequencer state encoding, YES/NO constants and the test-pattern function.
package eeprom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_CHK,
        RD_GAP,
        FIN
    } state_t;

    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;

    // Byte stored at an address: low address byte keyed with the seed.
    function automatic logic [7:0] pattern(input logic [7:0] addr, input logic [7:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/eeprom_cmd_tmo.sv
// Cycle counter that flags expiry after LIMIT enabled cycles.
// Used both as the ACK timeout and as the inter-command gap timer.
module eeprom_cmd_tmo #(
    parameter int LIMIT = 4096
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry is seen during the LIMIT-th enabled cycle so the caller can leave on that edge.
    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eeprom_cmd_seq.sv
// Write-then-verify command sequencer driving the EEPROM controller handshake.
// Writes LEN pattern bytes from BASE_ADDR, reads them back and reports mismatches or ACK timeout.
module eeprom_cmd_seq
    import eeprom_pkg::*;
#(
    parameter int          ADDR_W      = 11,
    parameter int          DATA_W      = 8,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int          GAP_CYC     = 4,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [7:0]        LEN,
    output logic              WR,
    output logic              RD,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] DATA,
    input  logic              ACK,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              TMO,
    output logic [7:0]        ERR_CNT,
    output logic [ADDR_W-1:0] ERR_ADDR
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [7:0]         len_q, len_d;
    logic [8:0]         idx_q, idx_d;
    logic [DATA_W-1:0]  rd_byte_q, rd_byte_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               tmo_q, tmo_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;

    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  exp_byte;
    logic [8:0]         idx_inc;
    logic               last_idx;
    logic               in_req;
    logic               in_gap;
    logic               tmo_expired;
    logic               gap_expired;

    // idx is one bit wider than LEN so the LEN=255 comparison cannot wrap.
    assign cur_addr = base_q + ADDR_W'(idx_q);
    assign exp_byte = DATA_W'(pattern(cur_addr[7:0], SEED));
    assign idx_inc  = idx_q + 9'd1;
    assign last_idx = (idx_inc == {1'b0, len_q});
    assign in_req   = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign in_gap   = (state_q == WR_GAP) || (state_q == RD_GAP);

    eeprom_cmd_tmo #(.LIMIT(TIMEOUT_CYC)) u_tmo (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr_i     (!in_req),
        .en_i      (in_req),
        .expired_o (tmo_expired)
    );

    eeprom_cmd_tmo #(.LIMIT(GAP_CYC)) u_gap (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr_i     (!in_gap),
        .en_i      (in_gap),
        .expired_o (gap_expired)
    );

    assign WR       = (state_q == WR_REQ);
    assign RD       = (state_q == RD_REQ);
    assign ADDR     = cur_addr;
    assign DATA     = (state_q == WR_REQ) ? exp_byte : 'z;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign TMO      = tmo_q;
    assign ERR_CNT  = err_cnt_q;
    assign ERR_ADDR = err_addr_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        rd_byte_d  = rd_byte_q;
        busy_d     = busy_q;
        done_d     = NO;
        err_d      = err_q;
        tmo_d      = tmo_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    base_d     = BASE_ADDR;
                    len_d      = LEN;
                    idx_d      = '0;
                    err_d      = NO;
                    tmo_d      = NO;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    busy_d     = YES;
                    state_d    = (LEN == 8'd0) ? FIN : WR_REQ;
                end
            end
            WR_REQ: begin
                if (ACK) begin
                    state_d = WR_GAP;
                end else if (tmo_expired) begin
                    tmo_d   = YES;
                    err_d   = YES;
                    state_d = FIN;
                end
            end
            WR_GAP: begin
                if (gap_expired) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = RD_REQ;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (ACK) begin
                    rd_byte_d = DATA;
                    state_d   = RD_CHK;
                end else if (tmo_expired) begin
                    tmo_d   = YES;
                    err_d   = YES;
                    state_d = FIN;
                end
            end
            RD_CHK: begin
                // Only the first failing address is kept; later mismatches just count.
                if (rd_byte_q != exp_byte) begin
                    err_d = YES;
                    if (err_cnt_q == 8'd0) begin
                        err_addr_d = cur_addr;
                    end
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                state_d = RD_GAP;
            end
            RD_GAP: begin
                if (gap_expired) begin
                    if (last_idx) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = RD_REQ;
                    end
                end
            end
            FIN: begin
                done_d  = YES;
                busy_d  = NO;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rd_byte_q  <= '0;
            busy_q     <= NO;
            done_q     <= NO;
            err_q      <= NO;
            tmo_q      <= NO;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rd_byte_q  <= rd_byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// Bench for eeprom_cmd_seq: a behavioural EEPROM ACK responder plus directed runs
// with hand-computed addresses, pattern bytes and status values.
module tb_eeprom_cmd_seq;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [10:0] BASE_ADDR;
    logic [7:0]  LEN;
    logic        ACK;
    wire         WR;
    wire         RD;
    wire  [10:0] ADDR;
    wire  [7:0]  DATA;
    wire         BUSY;
    wire         DONE;
    wire         ERR;
    wire         TMO;
    wire  [7:0]  ERR_CNT;
    wire  [10:0] ERR_ADDR;

    logic        tbDrive;
    logic [7:0]  tbData;
    logic        ackEnable;
    logic        corruptEn;
    logic        corruptAll;
    logic [10:0] corruptAddr;
    logic [7:0]  mem [0:2047];
    int          waitCnt;

    int          wrN, rdN, wrHigh, rdHigh, doneCount;
    logic [10:0] wrAddrLog [0:255];
    logic [7:0]  wrDataLog [0:255];
    logic [10:0] rdAddrLog [0:255];

    int          compared;
    int          mismatched;

    assign DATA = tbDrive ? tbData : 8'hzz;

    always #5 CLK = ~CLK;

    eeprom_cmd_seq #(
        .ADDR_W      (11),
        .DATA_W      (8),
        .SEED        (8'hA5),
        .GAP_CYC     (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .BASE_ADDR (BASE_ADDR),
        .LEN       (LEN),
        .WR        (WR),
        .RD        (RD),
        .ADDR      (ADDR),
        .DATA      (DATA),
        .ACK       (ACK),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .TMO       (TMO),
        .ERR_CNT   (ERR_CNT),
        .ERR_ADDR  (ERR_ADDR)
    );

    // EEPROM stand-in: ACKs each request on its second cycle, logs traffic, can corrupt reads.
    always @(negedge CLK) begin
        if (WR) wrHigh++;
        if (RD) rdHigh++;
        if (DONE) doneCount++;
        if ((WR || RD) && ackEnable && !ACK) begin
            waitCnt++;
            if (waitCnt >= 2) begin
                ACK = 1'b1;
                if (WR) begin
                    mem[ADDR] = DATA;
                    if (wrN < 256) begin
                        wrAddrLog[wrN] = ADDR;
                        wrDataLog[wrN] = DATA;
                    end
                    wrN++;
                end else begin
                    tbData = mem[ADDR];
                    if (corruptAll || (corruptEn && ADDR == corruptAddr)) tbData = tbData ^ 8'hFF;
                    tbDrive = 1'b1;
                    if (rdN < 256) rdAddrLog[rdN] = ADDR;
                    rdN++;
                end
            end
        end else begin
            ACK     = 1'b0;
            tbDrive = 1'b0;
            waitCnt = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulses START for one cycle; returns at the first negedge after START was sampled.
    task automatic applyStimulus(input logic [10:0] base, input logic [7:0] len);
        @(negedge CLK);
        wrN       = 0;
        rdN       = 0;
        wrHigh    = 0;
        rdHigh    = 0;
        doneCount = 0;
        BASE_ADDR = base;
        LEN       = len;
        START     = 1'b1;
        @(negedge CLK);
        START     = 1'b0;
        BASE_ADDR = '0;
        LEN       = '0;
    endtask

    // Returns at the negedge where DONE is high, or after maxCyc cycles without it.
    task automatic waitDone(input string tag, input int maxCyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCyc && !seen; i++) begin
            if (DONE) seen = 1'b1;
            else @(negedge CLK);
        end
        checkOutput(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        RESET       = 1'b1;
        START       = 1'b0;
        BASE_ADDR   = '0;
        LEN         = '0;
        ACK         = 1'b0;
        tbDrive     = 1'b0;
        tbData      = '0;
        ackEnable   = 1'b1;
        corruptEn   = 1'b0;
        corruptAll  = 1'b0;
        corruptAddr = '0;
        waitCnt     = 0;
        wrN = 0; rdN = 0; wrHigh = 0; rdHigh = 0; doneCount = 0;

        repeat (3) @(negedge CLK);
        checkOutput("rstWr", {31'd0, WR}, 32'd0);
        checkOutput("rstRd", {31'd0, RD}, 32'd0);
        checkOutput("rstBusy", {31'd0, BUSY}, 32'd0);
        checkOutput("rstDone", {31'd0, DONE}, 32'd0);
        checkOutput("rstErr", {30'd0, ERR, TMO}, 32'd0);
        checkOutput("rstErrCnt", {24'd0, ERR_CNT}, 32'd0);
        checkOutput("rstErrAddr", {21'd0, ERR_ADDR}, 32'd0);
        checkOutput("rstAddr", {21'd0, ADDR}, 32'd0);
        RESET = 1'b0;

        $display("[TB] run 1: base 0x010 len 4, clean");
        applyStimulus(11'h010, 8'd4);
        checkOutput("r1FirstWr", {31'd0, WR}, 32'd1);
        checkOutput("r1FirstRd", {31'd0, RD}, 32'd0);
        checkOutput("r1FirstAddr", {21'd0, ADDR}, 32'h010);
        checkOutput("r1FirstData", {24'd0, DATA}, 32'hB5);
        checkOutput("r1Busy", {31'd0, BUSY}, 32'd1);
        waitDone("r1Done", 2000);
        checkOutput("r1BusyAtDone", {31'd0, BUSY}, 32'd0);
        checkOutput("r1WrAddr0", {21'd0, wrAddrLog[0]}, 32'h010);
        checkOutput("r1WrAddr3", {21'd0, wrAddrLog[3]}, 32'h013);
        checkOutput("r1WrData", {wrDataLog[0], wrDataLog[1], wrDataLog[2], wrDataLog[3]}, 32'hB5B4B7B6);
        checkOutput("r1RdAddr0", {21'd0, rdAddrLog[0]}, 32'h010);
        checkOutput("r1RdAddr3", {21'd0, rdAddrLog[3]}, 32'h013);
        checkOutput("r1Counts", {wrN[15:0], rdN[15:0]}, {16'd4, 16'd4});
        checkOutput("r1Err", {30'd0, ERR, TMO}, 32'd0);
        checkOutput("r1ErrCnt", {24'd0, ERR_CNT}, 32'd0);

        $display("[TB] run 2: base 0x010 len 4, byte at 0x012 corrupted");
        corruptEn   = 1'b1;
        corruptAddr = 11'h012;
        applyStimulus(11'h010, 8'd4);
        waitDone("r2Done", 2000);
        checkOutput("r2RdsAtDone", rdN, 32'd4);
        checkOutput("r2Err", {31'd0, ERR}, 32'd1);
        checkOutput("r2Tmo", {31'd0, TMO}, 32'd0);
        checkOutput("r2ErrCnt", {24'd0, ERR_CNT}, 32'd1);
        checkOutput("r2ErrAddr", {21'd0, ERR_ADDR}, 32'h012);
        repeat (4) @(negedge CLK);
        checkOutput("r2DoneOnce", doneCount, 32'd1);
        corruptEn = 1'b0;

        $display("[TB] run 3: base 0x7FE len 3, address wrap");
        applyStimulus(11'h7FE, 8'd3);
        waitDone("r3Done", 2000);
        checkOutput("r3WrAddr", {wrAddrLog[0][7:0], wrAddrLog[1][7:0], wrAddrLog[2][7:0], 8'd0}, 32'hFEFF0000);
        checkOutput("r3WrAddrHi", {29'd0, wrAddrLog[0][10:8] & wrAddrLog[1][10:8]}, 32'd7);
        checkOutput("r3WrAddr2", {21'd0, wrAddrLog[2]}, 32'h000);
        checkOutput("r3WrData", {8'd0, wrDataLog[0], wrDataLog[1], wrDataLog[2]}, 32'h005B5AA5);
        checkOutput("r3RdAddr", {rdAddrLog[0], rdAddrLog[2]}, {11'h7FE, 11'h000});
        checkOutput("r3RdAddr1", {21'd0, rdAddrLog[1]}, 32'h7FF);
        checkOutput("r3Err", {30'd0, ERR, TMO}, 32'd0);

        $display("[TB] run 4: no ACK, timeout after 16 cycles");
        ackEnable = 1'b0;
        applyStimulus(11'h100, 8'd2);
        waitDone("r4Done", 200);
        checkOutput("r4WrHigh", wrHigh, 32'd16);
        checkOutput("r4RdHigh", rdHigh, 32'd0);
        checkOutput("r4Tmo", {31'd0, TMO}, 32'd1);
        checkOutput("r4Err", {31'd0, ERR}, 32'd1);
        checkOutput("r4ErrCnt", {24'd0, ERR_CNT}, 32'd0);
        ackEnable = 1'b1;

        $display("[TB] run 5: len 0 with a second START while busy");
        @(negedge CLK);
        wrN = 0; rdN = 0; wrHigh = 0; rdHigh = 0; doneCount = 0;
        BASE_ADDR = 11'h050;
        LEN       = 8'd0;
        START     = 1'b1;
        @(negedge CLK);
        checkOutput("r5Busy", {31'd0, BUSY}, 32'd1);
        checkOutput("r5DoneEarly", {31'd0, DONE}, 32'd0);
        BASE_ADDR = 11'h060;
        LEN       = 8'd1;
        @(negedge CLK);
        START     = 1'b0;
        LEN       = 8'd0;
        checkOutput("r5Done", {31'd0, DONE}, 32'd1);
        checkOutput("r5BusyAtDone", {31'd0, BUSY}, 32'd0);
        repeat (6) @(negedge CLK);
        checkOutput("r5DoneOnce", doneCount, 32'd1);
        checkOutput("r5NoCmds", wrHigh + rdHigh, 32'd0);
        checkOutput("r5Idle", {31'd0, BUSY}, 32'd0);
        checkOutput("r5ErrCleared", {30'd0, ERR, TMO}, 32'd0);

        $display("[TB] run 6: reset during a read request");
        applyStimulus(11'h020, 8'd2);
        for (int i = 0; i < 200 && !RD; i++) @(negedge CLK);
        checkOutput("r6RdSeen", {31'd0, RD}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("r6RdDrop", {30'd0, RD, WR}, 32'd0);
        checkOutput("r6BusyDrop", {31'd0, BUSY}, 32'd0);
        checkOutput("r6NoDone", {31'd0, DONE}, 32'd0);
        RESET = 1'b0;
        repeat (10) @(negedge CLK);
        checkOutput("r6NoDoneLater", doneCount, 32'd0);
        checkOutput("r6StillIdle", rdN, 32'd0);
        applyStimulus(11'h030, 8'd2);
        waitDone("r6RerunDone", 2000);
        checkOutput("r6RerunCounts", {wrN[15:0], rdN[15:0]}, {16'd2, 16'd2});
        checkOutput("r6RerunErr", {30'd0, ERR, TMO}, 32'd0);

        $display("[TB] run 7: len 255, every read corrupted");
        corruptAll = 1'b1;
        applyStimulus(11'h100, 8'd255);
        waitDone("r7Done", 8000);
        checkOutput("r7Counts", {wrN[15:0], rdN[15:0]}, {16'd255, 16'd255});
        checkOutput("r7ErrCnt", {24'd0, ERR_CNT}, 32'hFF);
        checkOutput("r7ErrAddr", {21'd0, ERR_ADDR}, 32'h100);
        checkOutput("r7LastWrAddr", {21'd0, wrAddrLog[254]}, 32'h1FE);
        checkOutput("r7LastWrData", {24'd0, wrDataLog[254]}, 32'h5B);
        corruptAll = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
